control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL expose ports (name  direction  width  meaning):
- clk  in  1  clock; state updates on rising edge
- clr  in  1  async active-low reset
- ir  in  32  IR_Data from datapath; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
- start  in  1  begin fetching when idle
- stop  in  1  return to idle after the current instruction completes
- mem_ready  in  1  memory read data valid on MDataIN
- PC_select, Z_LO_select, Z_HI_select, MDR_select  out  1 each  bus source selects
- PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, HI_enable, LO_enable  out  1 each  register load enables
- read  out  1  MDR mux selects memory data
- reg_select  out  16  one-hot r0..r15 bus select
- reg_enable  out  16  one-hot r0..r15 load enable
- alu_instruction  out  5  ALU opcode
- step  out  4  current state code
- run  out  1  high when not IDLE and not HALT
- illegal  out  1  one-cycle flag for an undefined opcode

Function
REQ-003 SHALL be a Moore FSM; all outputs SHALL be decoded from the state register and ir only; unlisted outputs SHALL be 0 in each state.
REQ-004 SHALL use these states and step codes: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8.
REQ-005 IDLE: all outputs 0; start=1 SHALL go to T0, else stay in IDLE.
REQ-006 T0: PC_select, MAR_enable, PC_increment_enable, Z_enable; next state is T1.
REQ-007 T1: Z_LO_select, PC_enable, read, MDR_enable; SHALL stay in T1 while mem_ready=0 and go to T2 when mem_ready=1.
REQ-008 T2: MDR_select, IR_enable; next state is T3.
REQ-009 Opcode classes:
- 00000-01100: ALU3, Ra <- Rb op Rc
- 01110, 01111: MULDIV, HI/LO <- Ra op Rb
- 11010: NOP
- 11011: HALT
- all other opcodes: illegal
REQ-010 T3, by class:
- ALU3: reg_select[Rb], Y_enable
- MULDIV: reg_select[Ra], Y_enable
- NOP: no outputs
- illegal: illegal=1
- HALT: go to HALT
- NOP or illegal: go to T0, or to IDLE if stop=1
- ALU3 or MULDIV: go to T4
REQ-011 T4: reg_select[Rc] for ALU3 or reg_select[Rb] for MULDIV, plus alu_instruction=ir[31:27] and Z_enable; next state is T5. alu_instruction SHALL be 0 in every state other than T4.
REQ-012 T5: Z_LO_select, plus reg_enable[Ra] for ALU3 or LO_enable for MULDIV.
- ALU3: go to T0, or to IDLE if stop=1
- MULDIV: go to T6
REQ-013 T6: Z_HI_select, HI_enable; go to T0, or to IDLE if stop=1.
REQ-014 HALT: all outputs 0 and run=0; start and stop SHALL be ignored; only clr exits HALT.
REQ-015 Bus-select outputs SHALL be mutually exclusive; at most one bit of reg_select and at most one bit of reg_enable SHALL be set in any cycle.
REQ-016 stop SHALL only be sampled at the instruction-end transitions listed above; stop never aborts an instruction mid-flight.
REQ-017 ir SHALL be treated as stable from T3 through T6; the block SHALL NOT latch ir.
REQ-018 Writes to R0 SHALL be permitted (reg_enable[0]); the block SHALL NOT special-case R0.

Reset
REQ-019 clr=0 SHALL force state IDLE and all outputs to 0 immediately, independent of clk, including mid-instruction and during a T1 wait.
REQ-020 After clr returns high, the FSM SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-021 Reset, mem_ready=1, start pulse, ir=0x28918000 -> steps 1,2,3,4,5,6 then back to 1:
- T3: reg_select=0x0004, Y_enable=1
- T4: reg_select=0x0008, alu_instruction=00101, Z_enable=1
- T5: reg_enable=0x0002, Z_LO_select=1
REQ-022 mem_ready held low for 3 cycles in T1 -> step=2 for 4 cycles with read, MDR_enable and PC_enable held high, then step=3.
REQ-023 ir=0x72280000 (mul, Ra=4, Rb=5):
- T3: reg_select=0x0010
- T4: reg_select=0x0020, alu_instruction=01110
- T5: LO_enable=1
- T6: Z_HI_select=1, HI_enable=1
REQ-024 ir=0xD8000000 -> after T3, step=8 and run=0; further start pulses produce no change; clr low returns step to 0.
REQ-025 Illegal and stop cases:
- ir=0xF8000000 -> illegal=1 for exactly one cycle in T3, then T0.
- stop=1 asserted in T4 of an ALU3 instruction -> after T5, step=0 and run=0.
REQ-026 clr dropped mid-T1 -> all outputs 0 within the same cycle without a clock edge; a subsequent start re-enters T0.
REQ-027 Every cycle of every scenario SHALL be checked for the exclusivity rule of REQ-015.

Source files
------------

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction, handshake and control-strobe bundle between sequencer and datapath
interface control_sequencer_if;
  logic [31:0] ir;
  logic        start;
  logic        stop;
  logic        mem_ready;
  logic        PC_select;
  logic        Z_LO_select;
  logic        Z_HI_select;
  logic        MDR_select;
  logic        PC_enable;
  logic        PC_increment_enable;
  logic        IR_enable;
  logic        Y_enable;
  logic        Z_enable;
  logic        MAR_enable;
  logic        MDR_enable;
  logic        HI_enable;
  logic        LO_enable;
  logic        read;
  logic [15:0] reg_select;
  logic [15:0] reg_enable;
  logic [4:0]  alu_instruction;
  logic [3:0]  step;
  logic        run;
  logic        illegal;
  modport slave (
    input  ir, start, stop, mem_ready,
    output PC_select, Z_LO_select, Z_HI_select, MDR_select,
    output PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
    output MAR_enable, MDR_enable, HI_enable, LO_enable, read,
    output reg_select, reg_enable, alu_instruction, step, run, illegal
  );
  modport master (
    output ir, start, stop, mem_ready,
    input  PC_select, Z_LO_select, Z_HI_select, MDR_select,
    input  PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
    input  MAR_enable, MDR_enable, HI_enable, LO_enable, read,
    input  reg_select, reg_enable, alu_instruction, step, run, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM sequencing fetch and execute micro-steps for a bus-based datapath
module control_sequencer (
  input  logic               clk,
  input  logic               clr,
  control_sequencer_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
    T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, HALT = 4'd8
  } state_t;
  state_t      r_state;
  state_t      w_next;
  logic [4:0]  w_op;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  logic        w_alu3;
  logic        w_muldiv;
  logic        w_nop;
  logic        w_halt;
  logic        w_illegal;
  assign w_op      = bus.ir[31:27];
  assign w_ra      = bus.ir[26:23];
  assign w_rb      = bus.ir[22:19];
  assign w_rc      = bus.ir[18:15];
  assign w_alu3    = w_op <= 5'd12;
  assign w_muldiv  = w_op[4:1] == 4'b0111;
  assign w_nop     = w_op == 5'd26;
  assign w_halt    = w_op == 5'd27;
  assign w_illegal = !(w_alu3 || w_muldiv || w_nop || w_halt);
  // state register; clr drops straight to IDLE so every output clears without a clock
  always_ff @(posedge clk or negedge clr)
    if (!clr) r_state <= IDLE;
    else      r_state <= w_next;
  // next-state and output decode from state and ir only
  always_comb begin
    w_next                  = r_state;
    bus.PC_select           = 1'b0;
    bus.Z_LO_select         = 1'b0;
    bus.Z_HI_select         = 1'b0;
    bus.MDR_select          = 1'b0;
    bus.PC_enable           = 1'b0;
    bus.PC_increment_enable = 1'b0;
    bus.IR_enable           = 1'b0;
    bus.Y_enable            = 1'b0;
    bus.Z_enable            = 1'b0;
    bus.MAR_enable          = 1'b0;
    bus.MDR_enable          = 1'b0;
    bus.HI_enable           = 1'b0;
    bus.LO_enable           = 1'b0;
    bus.read                = 1'b0;
    bus.reg_select          = 16'd0;
    bus.reg_enable          = 16'd0;
    bus.alu_instruction     = 5'd0;
    bus.illegal             = 1'b0;
    bus.step                = r_state;
    bus.run                 = r_state != IDLE && r_state != HALT;
    case (r_state)
      IDLE: w_next = bus.start ? T0 : IDLE;
      T0: begin
        bus.PC_select           = 1'b1;
        bus.MAR_enable          = 1'b1;
        bus.PC_increment_enable = 1'b1;
        bus.Z_enable            = 1'b1;
        w_next                  = T1;
      end
      T1: begin
        bus.Z_LO_select = 1'b1;
        bus.PC_enable   = 1'b1;
        bus.read        = 1'b1;
        bus.MDR_enable  = 1'b1;
        w_next          = bus.mem_ready ? T2 : T1;
      end
      T2: begin
        bus.MDR_select = 1'b1;
        bus.IR_enable  = 1'b1;
        w_next         = T3;
      end
      T3: begin
        bus.reg_select = w_alu3 ? 16'd1 << w_rb : w_muldiv ? 16'd1 << w_ra : 16'd0;
        bus.Y_enable   = w_alu3 | w_muldiv;
        bus.illegal    = w_illegal;
        w_next         = w_halt ? HALT : (w_alu3 || w_muldiv) ? T4 : bus.stop ? IDLE : T0;
      end
      T4: begin
        bus.reg_select      = w_muldiv ? 16'd1 << w_rb : 16'd1 << w_rc;
        bus.alu_instruction = w_op;
        bus.Z_enable        = 1'b1;
        w_next              = T5;
      end
      T5: begin
        bus.Z_LO_select = 1'b1;
        bus.reg_enable  = w_muldiv ? 16'd0 : 16'd1 << w_ra;
        bus.LO_enable   = w_muldiv;
        w_next          = w_muldiv ? T6 : bus.stop ? IDLE : T0;
      end
      T6: begin
        bus.Z_HI_select = 1'b1;
        bus.HI_enable   = 1'b1;
        w_next          = bus.stop ? IDLE : T0;
      end
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
  end
endmodule
